// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LATCH = 2'd2
    } fetch_state_t;

    localparam int TIMEOUT_W          = 8;
    localparam int DEFAULT_ADDR_WIDTH = 16;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating wait-cycle counter; flags expiry once the count equals TIMEOUT.
module fetch_timeout_counter
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads memory with a ready
// handshake and hands each word to the instruction register.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [15:0]           instr_data,
    output logic                  ir_we,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  fetch_done,
    output logic                  fetch_err
);

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [15:0]           instr_q;
    logic                  redir_pend;
    logic [ADDR_WIDTH-1:0] redir_val;
    logic                  err_q;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  expired;
    logic                  take_word;
    logic                  timed_out;

    assign take_word = (state == REQ) && mem_ready;
    assign timed_out = (state == REQ) && !mem_ready && expired;

    // The counter runs from the edge that enters REQ, so expiry lands on the
    // TIMEOUT-th REQ cycle and the error pulse follows one cycle later.
    assign cnt_en  = (next_state == REQ);
    assign cnt_clr = !cnt_en;

    fetch_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fetch_req) next_state = REQ;
            REQ: begin
                if (mem_ready) begin
                    next_state = LATCH;
                end else if (expired) begin
                    next_state = IDLE;
                end
            end
            LATCH:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        busy       = 1'b0;
        ir_we      = 1'b0;
        fetch_done = 1'b0;
        case (state)
            REQ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
            end
            LATCH: begin
                busy       = 1'b1;
                ir_we      = 1'b1;
                fetch_done = 1'b1;
            end
            default: ;
        endcase
    end

    // A redirect seen in the exit cycle itself is the newest, so it beats
    // any value already parked in the pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            redir_pend <= 1'b0;
            redir_val  <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= timed_out;
            if (take_word) begin
                instr_q <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (pc_load) pc_q <= pc_load_val;
                end
                REQ: begin
                    if (timed_out) begin
                        if (pc_load) begin
                            pc_q <= pc_load_val;
                        end else if (redir_pend) begin
                            pc_q <= redir_val;
                        end
                        redir_pend <= 1'b0;
                    end else if (pc_load) begin
                        redir_pend <= 1'b1;
                        redir_val  <= pc_load_val;
                    end
                end
                LATCH: begin
                    if (pc_load) begin
                        pc_q <= pc_load_val;
                    end else if (redir_pend) begin
                        pc_q <= redir_val;
                    end else begin
                        pc_q <= pc_q + ADDR_WIDTH'(1);
                    end
                    redir_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pc         = pc_q;
    assign mem_addr   = pc_q;
    assign instr_data = instr_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_instr_fetch_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int   NUM_VECS = 27;

    typedef struct {
        logic        fetch_req;
        logic        pc_load;
        logic [15:0] pc_load_val;
        logic        mem_ready;
        logic [15:0] mem_rdata;
        logic        exp_mem_rd;
        logic        exp_ir_we;
        logic        exp_busy;
        logic        exp_err;
        logic [15:0] exp_pc;
        logic [15:0] exp_instr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] instr_data;
    logic        ir_we;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;

    int   assert_count;
    int   fail_count;
    vec_t vecs [NUM_VECS];

    instr_fetch_unit #(
        .ADDR_WIDTH(16),
        .RESET_PC  (16'h0000),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .instr_data (instr_data),
        .ir_we      (ir_we),
        .pc         (pc),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        fetch_req   = v.fetch_req;
        pc_load     = v.pc_load;
        pc_load_val = v.pc_load_val;
        mem_ready   = v.mem_ready;
        mem_rdata   = v.mem_rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_rd, input logic e_we,
                             input logic e_busy, input logic e_err,
                             input logic [15:0] e_pc, input logic [15:0] e_instr);
        checkOutput({tag, " mem_rd"},     32'(mem_rd),     32'(e_rd));
        checkOutput({tag, " ir_we"},      32'(ir_we),      32'(e_we));
        checkOutput({tag, " fetch_done"}, 32'(fetch_done), 32'(e_we));
        checkOutput({tag, " busy"},       32'(busy),       32'(e_busy));
        checkOutput({tag, " fetch_err"},  32'(fetch_err),  32'(e_err));
        checkOutput({tag, " pc"},         32'(pc),         32'(e_pc));
        checkOutput({tag, " mem_addr"},   32'(mem_addr),   32'(e_pc));
        checkOutput({tag, " instr_data"}, 32'(instr_data), 32'(e_instr));
    endtask

    // Timeout with memory never ready: four REQ cycles, error in cycle 5.
    task automatic run_timeout(input logic redirect, input logic [15:0] pc_before,
                               input logic [15:0] pc_after, input logic [15:0] instr_keep);
        string tag;
        logic  saw_we;
        saw_we    = 1'b0;
        fetch_req = 1'b1;
        pc_load   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check_all(redirect ? "to_rd c0" : "to c0", L, L, L, L, pc_before, instr_keep);
        next_cycle();
        fetch_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            pc_load     = redirect && (c == 2);
            pc_load_val = 16'h0033;
            mem_ready   = (c >= 5);
            mem_rdata   = 16'hDEAD;
            @(negedge clk);
            saw_we = saw_we | ir_we;
            tag = $sformatf("%s c%0d", redirect ? "to_rd" : "to", c);
            check_all(tag, (c <= 4), L, (c <= 4), (c == 5),
                      (c <= 4) ? pc_before : pc_after, instr_keep);
            next_cycle();
        end
        checkOutput(redirect ? "to_rd no_ir_we" : "to no_ir_we", 32'(saw_we), 32'(0));
        pc_load   = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;

        //            req lod val       rdy rdata      rd we bsy err pc        instr
        vecs[0]  = '{H, L, 16'h0000, L, 16'h0000, L, L, L, L, 16'h0000, 16'h0000};
        vecs[1]  = '{L, L, 16'h0000, H, 16'hA5C3, H, L, H, L, 16'h0000, 16'h0000};
        vecs[2]  = '{L, L, 16'h0000, L, 16'h0000, L, H, H, L, 16'h0000, 16'hA5C3};
        vecs[3]  = '{H, L, 16'h0000, L, 16'h0000, L, L, L, L, 16'h0001, 16'hA5C3};
        vecs[4]  = '{L, L, 16'h0000, L, 16'h0000, H, L, H, L, 16'h0001, 16'hA5C3};
        vecs[5]  = '{L, L, 16'h0000, L, 16'h0000, H, L, H, L, 16'h0001, 16'hA5C3};
        vecs[6]  = '{L, L, 16'h0000, L, 16'h0000, H, L, H, L, 16'h0001, 16'hA5C3};
        vecs[7]  = '{L, L, 16'h0000, H, 16'h1234, H, L, H, L, 16'h0001, 16'hA5C3};
        vecs[8]  = '{L, L, 16'h0000, L, 16'h0000, L, H, H, L, 16'h0001, 16'h1234};
        vecs[9]  = '{L, H, 16'h0005, L, 16'h0000, L, L, L, L, 16'h0002, 16'h1234};
        vecs[10] = '{H, L, 16'h0000, L, 16'h0000, L, L, L, L, 16'h0005, 16'h1234};
        vecs[11] = '{L, H, 16'h0040, L, 16'h0000, H, L, H, L, 16'h0005, 16'h1234};
        vecs[12] = '{L, L, 16'h0000, H, 16'hBEEF, H, L, H, L, 16'h0005, 16'h1234};
        vecs[13] = '{L, L, 16'h0000, L, 16'h0000, L, H, H, L, 16'h0005, 16'hBEEF};
        vecs[14] = '{H, H, 16'h0100, L, 16'h0000, L, L, L, L, 16'h0040, 16'hBEEF};
        vecs[15] = '{L, L, 16'h0000, H, 16'h7777, H, L, H, L, 16'h0100, 16'hBEEF};
        vecs[16] = '{L, L, 16'h0000, L, 16'h0000, L, H, H, L, 16'h0100, 16'h7777};
        vecs[17] = '{H, H, 16'hFFFF, L, 16'h0000, L, L, L, L, 16'h0101, 16'h7777};
        vecs[18] = '{L, L, 16'h0000, H, 16'hCAFE, H, L, H, L, 16'hFFFF, 16'h7777};
        vecs[19] = '{H, L, 16'h0000, L, 16'h0000, L, H, H, L, 16'hFFFF, 16'hCAFE};
        vecs[20] = '{H, L, 16'h0000, H, 16'h0F0F, L, L, L, L, 16'h0000, 16'hCAFE};
        vecs[21] = '{H, L, 16'h0000, H, 16'h0101, H, L, H, L, 16'h0000, 16'hCAFE};
        vecs[22] = '{H, L, 16'h0000, H, 16'h0202, L, H, H, L, 16'h0000, 16'h0101};
        vecs[23] = '{H, L, 16'h0000, H, 16'h0303, L, L, L, L, 16'h0001, 16'h0101};
        vecs[24] = '{L, L, 16'h0000, H, 16'h0404, H, L, H, L, 16'h0001, 16'h0101};
        vecs[25] = '{L, H, 16'h0200, L, 16'h0000, L, H, H, L, 16'h0001, 16'h0404};
        vecs[26] = '{L, L, 16'h0000, L, 16'h0000, L, L, L, L, 16'h0200, 16'h0404};

        rst         = 1'b1;
        fetch_req   = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        mem_ready   = 1'b0;
        mem_rdata   = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset", L, L, L, L, 16'h0000, 16'h0000);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            check_all($sformatf("v%0d", i), vecs[i].exp_mem_rd, vecs[i].exp_ir_we,
                      vecs[i].exp_busy, vecs[i].exp_err, vecs[i].exp_pc,
                      vecs[i].exp_instr);
            next_cycle();
        end
        pc_load = 1'b0;

        run_timeout(1'b0, 16'h0200, 16'h0200, 16'h0404);
        run_timeout(1'b1, 16'h0200, 16'h0033, 16'h0404);

        // Asynchronous reset in the middle of a REQ cycle.
        fetch_req = 1'b1;
        next_cycle();
        fetch_req = 1'b0;
        mem_ready = 1'b0;
        #2;
        checkOutput("rst_mid pre mem_rd", 32'(mem_rd), 32'(1));
        rst = 1'b1;
        #1;
        checkOutput("rst_mid mem_rd",     32'(mem_rd),     32'(0));
        checkOutput("rst_mid busy",       32'(busy),       32'(0));
        checkOutput("rst_mid pc",         32'(pc),         32'(16'h0000));
        checkOutput("rst_mid mem_addr",   32'(mem_addr),   32'(16'h0000));
        checkOutput("rst_mid instr_data", 32'(instr_data), 32'(16'h0000));
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_all("post_rst idle", L, L, L, L, 16'h0000, 16'h0000);
        fetch_req = 1'b1;
        next_cycle();
        fetch_req = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'h5A5A;
        @(negedge clk);
        check_all("post_rst req", H, L, H, L, 16'h0000, 16'h0000);
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        check_all("post_rst latch", L, H, H, L, 16'h0000, 16'h5A5A);
        next_cycle();
        @(negedge clk);
        check_all("post_rst done", L, L, L, L, 16'h0001, 16'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
